// File: rtl/vga_timing_rx.sv
// VGA timing decoder: measures line/frame geometry from sampled syncs, recovers pixel coordinates, flags lock.
// Latency: 1 clk after the sampling p_tick (frame_done, pix, geometry); locked 1 clk after frame_done. No backpressure.
module vga_timing_rx #(
    parameter bit SYNC_ACTIVE_LOW = 1'b1,
    parameter int CNT_W           = 11,
    parameter int LOCK_FRAMES     = 2,
    parameter int TIMEOUT_CYC     = 200000
) (
    input  logic             clk_100MHz,
    input  logic             rst_n,
    input  logic             p_tick,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             de_in,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active,
    output logic [CNT_W-1:0] pixel_x,
    output logic [CNT_W-1:0] pixel_y,
    output logic             pix_valid,
    output logic             frame_done,
    output logic             locked
);
    localparam int MW = $clog2(LOCK_FRAMES + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0]    TO_MAX    = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0]    TO_LAST   = TW'(TIMEOUT_CYC - 1);
    localparam logic [MW-1:0]    LOCK_LAST = MW'(LOCK_FRAMES - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);

    typedef enum logic [1:0] {SEARCH, MEASURE, LOCKED} state_t;

    logic             hs, vs, hs_prev, vs_prev, de_prev;
    logic             hs_lead, vs_lead, de_rise, line_de;
    logic [CNT_W-1:0] h_cnt, de_cnt, line_cnt, act_lines;
    logic             y_first, line_de_seen;
    logic [TW-1:0]    to_cnt;
    logic             to_hit;
    state_t           state;
    logic [MW-1:0]    match_cnt;
    logic [4*CNT_W-1:0] snap, cur;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + ONE;
    endfunction

    assign hs      = SYNC_ACTIVE_LOW ? ~hsync_in : hsync_in;
    assign vs      = SYNC_ACTIVE_LOW ? ~vsync_in : vsync_in;
    assign hs_lead = p_tick & hs & ~hs_prev;
    assign vs_lead = p_tick & vs & ~vs_prev;
    assign de_rise = p_tick & de_in & ~de_prev;
    assign line_de = (de_cnt != '0);
    assign to_hit  = !hs_lead && (to_cnt == TO_LAST);
    assign cur     = {h_total, h_active, v_total, v_active};

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            hs_prev      <= 1'b0;
            vs_prev      <= 1'b0;
            de_prev      <= 1'b0;
            h_cnt        <= '0;
            de_cnt       <= '0;
            line_cnt     <= '0;
            act_lines    <= '0;
            y_first      <= 1'b0;
            line_de_seen <= 1'b0;
            h_total      <= '0;
            h_active     <= '0;
            v_total      <= '0;
            v_active     <= '0;
            pixel_x      <= '0;
            pixel_y      <= '0;
            pix_valid    <= 1'b0;
            frame_done   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (p_tick) begin
                hs_prev   <= hs;
                vs_prev   <= vs;
                de_prev   <= de_in;
                pix_valid <= de_in;

                // pixel_y advances only on the first de run of a line
                if (de_rise) begin
                    pixel_x <= '0;
                    if (y_first) begin
                        pixel_y <= '0;
                        y_first <= 1'b0;
                    end else if (!line_de_seen || hs_lead) begin
                        pixel_y <= sat_inc(pixel_y);
                    end
                end else if (de_in) begin
                    pixel_x <= sat_inc(pixel_x);
                end

                if (hs_lead) begin
                    h_total      <= sat_inc(h_cnt);
                    h_cnt        <= '0;
                    if (line_de)
                        h_active <= de_cnt;
                    de_cnt       <= de_in ? ONE : '0;
                    line_de_seen <= de_in;
                end else begin
                    h_cnt <= sat_inc(h_cnt);
                    if (de_in) begin
                        de_cnt       <= sat_inc(de_cnt);
                        line_de_seen <= 1'b1;
                    end
                end

                // a coincident hs edge closes its line into the ending frame
                if (vs_lead) begin
                    v_total    <= hs_lead ? sat_inc(line_cnt) : line_cnt;
                    v_active   <= (hs_lead && line_de) ? sat_inc(act_lines) : act_lines;
                    line_cnt   <= '0;
                    act_lines  <= '0;
                    y_first    <= 1'b1;
                    frame_done <= 1'b1;
                end else if (hs_lead) begin
                    line_cnt <= sat_inc(line_cnt);
                    if (line_de)
                        act_lines <= sat_inc(act_lines);
                end
            end
        end
    end

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n)
            to_cnt <= '0;
        else if (hs_lead)
            to_cnt <= '0;
        else if (to_cnt != TO_MAX)
            to_cnt <= to_cnt + 1'b1;
    end

    always_ff @(posedge clk_100MHz) begin
        if (!rst_n) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            match_cnt <= '0;
            snap      <= '0;
        end else if (to_hit) begin
            state     <= SEARCH;
            locked    <= 1'b0;
            match_cnt <= '0;
        end else if (frame_done) begin
            case (state)
                SEARCH: begin
                    snap      <= cur;
                    match_cnt <= MW'(1);
                    if (LOCK_FRAMES <= 1) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                    end else begin
                        state <= MEASURE;
                    end
                end
                MEASURE: begin
                    if (cur == snap) begin
                        match_cnt <= match_cnt + 1'b1;
                        if (match_cnt >= LOCK_LAST) begin
                            state  <= LOCKED;
                            locked <= 1'b1;
                        end
                    end else begin
                        snap      <= cur;
                        match_cnt <= MW'(1);
                    end
                end
                LOCKED: begin
                    if (cur != snap) begin
                        state     <= MEASURE;
                        locked    <= 1'b0;
                        snap      <= cur;
                        match_cnt <= MW'(1);
                    end
                end
                default: begin
                    state  <= SEARCH;
                    locked <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_vga_timing_rx.sv
// Bench for vga_timing_rx on a scaled-down stream: 20 ticks/line (3 hsync, de 6..15), 12 lines (2 vsync, de lines 3..10).
module tb_vga_timing_rx;
    localparam int TO = 400;

    logic        clk_100MHz = 1'b0;
    logic        rst_n = 1'b0, p_tick = 1'b0;
    logic        hsync_in = 1'b1, vsync_in = 1'b1, de_in = 1'b0;
    logic [10:0] h_total, h_active, v_total, v_active, pixel_x, pixel_y;
    logic        pix_valid, frame_done, locked;

    typedef struct {
        logic [10:0] ht, ha, vt, va;
        logic        lk, meas;
    } fexp_t;

    fexp_t       fq[$];
    logic [21:0] pq[$];
    int          total = 0, bad = 0, cyc = 0, last_tick_cyc = 0;
    logic        pix_chk_en = 1'b0, lk_pend = 1'b0, lk_exp = 1'b0;

    vga_timing_rx #(.SYNC_ACTIVE_LOW(1'b1), .CNT_W(11), .LOCK_FRAMES(2), .TIMEOUT_CYC(TO)) dut (
        .clk_100MHz(clk_100MHz), .rst_n(rst_n), .p_tick(p_tick),
        .hsync_in(hsync_in), .vsync_in(vsync_in), .de_in(de_in),
        .h_total(h_total), .h_active(h_active), .v_total(v_total), .v_active(v_active),
        .pixel_x(pixel_x), .pixel_y(pixel_y), .pix_valid(pix_valid),
        .frame_done(frame_done), .locked(locked)
    );

    always #5 clk_100MHz = ~clk_100MHz;
    always @(posedge clk_100MHz) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
        end
    endtask

    // Monitor / scoreboard
    always begin
        logic  tk;
        fexp_t e;
        logic [21:0] pe;
        @(posedge clk_100MHz);
        tk = p_tick;
        #1;
        if (lk_pend) begin
            chk("locked_after_fd", locked, lk_exp);
            lk_pend = 1'b0;
        end
        if (frame_done) begin
            if (fq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL fd_unexpected got=1 exp=0");
            end else begin
                e = fq.pop_front();
                if (e.meas) begin
                    chk("h_total", h_total, e.ht);
                    chk("h_active", h_active, e.ha);
                    chk("v_total", v_total, e.vt);
                    chk("v_active", v_active, e.va);
                end
                lk_pend = 1'b1;
                lk_exp  = e.lk;
            end
        end
        if (tk && pix_valid && pix_chk_en) begin
            if (pq.size() == 0) begin
                total++;
                bad++;
                $display("FAIL pix_unexpected got=1 exp=0");
            end else begin
                pe = pq.pop_front();
                chk("pixel_xy", {pixel_x, pixel_y}, pe);
            end
        end
    end

    task automatic push_fd(input int ht, input int ha, input int vt, input int va,
                           input logic lk, input logic meas);
        fexp_t e;
        e.ht = 11'(ht); e.ha = 11'(ha); e.vt = 11'(vt); e.va = 11'(va);
        e.lk = lk; e.meas = meas;
        fq.push_back(e);
    endtask

    task automatic tick(input logic hs, input logic vs, input logic de);
        @(negedge clk_100MHz);
        hsync_in = ~hs;
        vsync_in = ~vs;
        de_in    = de;
        p_tick   = 1'b1;
        @(posedge clk_100MHz);
        #1 last_tick_cyc = cyc;
        @(negedge clk_100MHz);
        p_tick = 1'b0;
        repeat (2) @(negedge clk_100MHz);
    endtask

    task automatic do_reset();
        @(negedge clk_100MHz);
        rst_n = 1'b0;
        repeat (3) @(negedge clk_100MHz);
        chk("rst_h_total", h_total, 0);
        chk("rst_h_active", h_active, 0);
        chk("rst_v_total", v_total, 0);
        chk("rst_v_active", v_active, 0);
        chk("rst_pixel_x", pixel_x, 0);
        chk("rst_pixel_y", pixel_y, 0);
        chk("rst_pix_valid", pix_valid, 0);
        chk("rst_frame_done", frame_done, 0);
        chk("rst_locked", locked, 0);
        rst_n = 1'b1;
    endtask

    task automatic gen_frame(input int h, input int rst_line);
        logic de;
        pix_chk_en = 1'b1;
        for (int l = 0; l < 12; l++) begin
            for (int t = 0; t < h; t++) begin
                if (l == rst_line && t == 4) begin
                    pix_chk_en = 1'b0;
                    do_reset();
                end
                de = (l >= 3 && l <= 10 && t >= 6 && t <= 15);
                if (de && pix_chk_en)
                    pq.push_back({11'(t - 6), 11'(l - 3)});
                tick(t < 3, l < 2, de);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

    initial begin
        int e;
        do_reset();
        push_fd(1, 0, 1, 0, 1'b0, 1'b1);       gen_frame(20, -1);
        push_fd(20, 10, 12, 8, 1'b0, 1'b1);    gen_frame(20, -1);
        push_fd(20, 10, 12, 8, 1'b1, 1'b1);    gen_frame(20, -1);
        push_fd(20, 10, 12, 8, 1'b1, 1'b1);    gen_frame(20, -1);
        push_fd(20, 10, 12, 8, 1'b1, 1'b1);    gen_frame(21, -1);
        push_fd(21, 10, 12, 8, 1'b0, 1'b1);    gen_frame(21, -1);
        push_fd(21, 10, 12, 8, 1'b1, 1'b1);    gen_frame(20, -1);
        push_fd(20, 10, 12, 8, 1'b0, 1'b1);    gen_frame(20, -1);
        push_fd(20, 10, 12, 8, 1'b1, 1'b1);    tick(1'b1, 1'b1, 1'b0);

        // hsync stalls: lock must hold until exactly TO clocks after the last hs edge
        e = last_tick_cyc;
        fork
            repeat (130) tick(1'b0, 1'b0, 1'b0);
            for (int n = 0; n < 600; n++) begin
                @(posedge clk_100MHz);
                #1;
                if (cyc == e + TO - 1) chk("lock_before_timeout", locked, 1);
                if (cyc == e + TO)     chk("lock_after_timeout", locked, 0);
            end
        join
        chk("hold_h_total", h_total, 20);
        chk("hold_h_active", h_active, 10);
        chk("hold_v_total", v_total, 12);
        chk("hold_v_active", v_active, 8);

        push_fd(0, 0, 0, 0, 1'b0, 1'b0);       gen_frame(20, -1);
        push_fd(20, 10, 12, 8, 1'b0, 1'b1);    gen_frame(20, -1);
        push_fd(20, 10, 12, 8, 1'b1, 1'b1);    gen_frame(20, 5);
        push_fd(20, 10, 7, 6, 1'b0, 1'b1);     gen_frame(20, -1);
        push_fd(20, 10, 12, 8, 1'b0, 1'b1);    gen_frame(20, -1);
        push_fd(20, 10, 12, 8, 1'b1, 1'b1);    tick(1'b1, 1'b1, 1'b0);

        repeat (10) @(negedge clk_100MHz);
        chk("fd_queue_drained", fq.size(), 0);
        chk("pix_queue_drained", pq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
